// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings,
// requester ids and the hold counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_LOAD = 1;

  // The counter must be able to hold HOLD_MAX itself.
  function automatic int hold_cnt_width(input int hold_max);
    return $clog2(hold_max + 1);
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: one-hot pick among req, fixed priority to
// requester 0 or round-robin against rr_last when rr_mode is set.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       rr_mode,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = (rr_mode && !rr_last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port word memory between core (0) and loader (1),
// with bounded lock ownership. Define MEM_ARB_RR_EN for round-robin ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int HOLD_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req,
  input  logic [1:0]               lock,
  input  logic [1:0]               we,
  input  logic [2*ADDR_WIDTH-1:0]  addr,
  input  logic [2*WORD_LENGTH-1:0] wdata,
  output logic [1:0]               gnt,
  output logic [1:0]               rvalid,
  output logic [WORD_LENGTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]    mem_address,
  output logic [ADDR_WIDTH-1:0]    mem_write_add,
  output logic [WORD_LENGTH-1:0]   mem_write_data,
  output logic                     mem_write_enable,
  output logic                     mem_read_enable,
  input  logic [WORD_LENGTH-1:0]   mem_data_out,
  output logic [1:0]               dbg_state
);

  localparam int HW = hold_cnt_width(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  state_t          state, state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [1:0]      lock_blk, lock_blk_nxt;
  logic [1:0]      pick, gnt_c, rd_gnt;
  logic            rr_last, rr_mode;
  logic            winner, any_gnt;

`ifdef MEM_ARB_RR_EN
  assign rr_mode = 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) rr_last <= 1'b1;
    else if (any_gnt) rr_last <= gnt[REQ_LOAD];
  end
`else
  assign rr_mode = 1'b0;
  assign rr_last = 1'b1;
`endif

  arb_pick2 u_pick (
    .req     (req),
    .rr_last (rr_last),
    .rr_mode (rr_mode),
    .pick    (pick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      lock_blk <= 2'b00;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      lock_blk <= lock_blk_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    gnt_c        = 2'b00;
    // A block only survives while its lock input stays asserted.
    lock_blk_nxt = lock_blk & lock;
    case (state)
      ST_IDLE: begin
        gnt_c = pick;
        if (pick[0] && lock[0] && !lock_blk[0]) begin
          state_nxt = ST_OWN0;
          hold_nxt  = HW'(1);
        end else if (pick[1] && lock[1] && !lock_blk[1]) begin
          state_nxt = ST_OWN1;
          hold_nxt  = HW'(1);
        end
      end
      ST_OWN0: begin
        gnt_c = {1'b0, req[0]};
        if (!lock[0]) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end else if (hold_cnt == HOLD_LIM) begin
          state_nxt       = ST_IDLE;
          hold_nxt        = '0;
          lock_blk_nxt[0] = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_OWN1: begin
        gnt_c = {req[1], 1'b0};
        if (!lock[1]) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end else if (hold_cnt == HOLD_LIM) begin
          state_nxt       = ST_IDLE;
          hold_nxt        = '0;
          lock_blk_nxt[1] = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // No access is granted while reset is asserted.
  assign gnt       = gnt_c & {2{rst}};
  assign any_gnt   = |gnt;
  assign winner    = gnt[REQ_LOAD];
  assign rd_gnt    = gnt & ~we;
  assign dbg_state = state;

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (any_gnt) begin
      if (winner) begin
        mem_address    = addr[REQ_LOAD*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_data = wdata[REQ_LOAD*WORD_LENGTH +: WORD_LENGTH];
      end else begin
        mem_address    = addr[REQ_CORE*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_data = wdata[REQ_CORE*WORD_LENGTH +: WORD_LENGTH];
      end
      mem_write_enable = we[winner];
      mem_read_enable  = !we[winner];
    end
  end

  assign mem_write_add = mem_address;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid <= 2'b00;
      rdata  <= '0;
    end else begin
      rvalid <= rd_gnt;
      if (|rd_gnt) rdata <= mem_data_out;
    end
  end

endmodule
